// File: rtl/ripple_carry_adder_if.sv
// rtl/ripple_carry_adder_if.sv - operand/result bus for the ripple-carry adder
// Purpose: groups the operand inputs and the registered results into one bundle.
// Signals:
//   a, b      operands (WIDTH bits)
//   ci        carry-in to the LSB stage
//   in_valid  qualifies a/b/ci for capture
//   s         registered sum (WIDTH bits)
//   cout      registered carry-out of the MSB stage
//   ovf       registered two's-complement overflow
//   out_valid high for the cycle in which s/cout/ovf hold a fresh result
// Modports: master drives the operands, slave (the adder) drives the results.
interface ripple_carry_adder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             out_valid;

  modport master (
    output a, b, ci, in_valid,
    input  s, cout, ovf, out_valid
  );

  modport slave (
    input  a, b, ci, in_valid,
    output s, cout, ovf, out_valid
  );
endinterface

// File: rtl/ripple_carry_adder_full_adder.sv
// rtl/ripple_carry_adder_full_adder.sv - purely combinational 1-bit full adder
// Purpose: one stage of the ripple chain.
// Ports:
//   a_i, b_i  operand bits
//   cin_i     carry in from the previous stage
//   sum_o     a_i ^ b_i ^ cin_i
//   cout_o    carry out to the next stage
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p      = a_i ^ b_i;
  assign sum_o  = p ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & p);
endmodule

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - registered WIDTH-bit ripple-carry adder
// Purpose: a + b + ci through a chain of full adders, result captured in an
//          output register (one-cycle latency, one operation per cycle).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, overrides in_valid
//   bus  slave side of ripple_carry_adder_if (operands in, registered results out)
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  ripple_carry_adder_if.slave bus
);
  // c[0] is the carry-in; c[i+1] is the carry out of stage i.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_w;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  assign c[0] = bus.ci;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      full_adder u_fa (
        .a_i    (bus.a[i]),
        .b_i    (bus.b[i]),
        .cin_i  (c[i]),
        .sum_o  (sum_w[i]),
        .cout_o (c[i+1])
      );
    end
  endgenerate

  // Results hold when no operation is presented; the strobe drops.
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      s_d    = sum_w;
      cout_d = c[WIDTH];
      // Signed overflow: carry into the sign bit differs from carry out of it.
      ovf_d  = c[WIDTH-1] ^ c[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb/tb_ripple_carry_adder.sv - directed self-checking bench for ripple_carry_adder
module tb_ripple_carry_adder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ripple_carry_adder_if #(.WIDTH(4)) bus ();

  ripple_carry_adder #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] es, input logic ec,
                           input logic eo, input logic ev);
    check({tag, ".s"}, 32'(bus.s), 32'(es));
    check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
  endtask

  // Apply inputs away from the edge, then return 1 time unit after the
  // capturing rising edge so the registered outputs can be sampled.
  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic ci, input logic v);
    @(negedge clk);
    rst          = r;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] full;
    int         sgn;
    logic       eovf;

    checks = 0;
    errors = 0;
    rst          = 1'b1;
    bus.a        = 4'd5;
    bus.b        = 4'd3;
    bus.ci       = 1'b1;
    bus.in_valid = 1'b1;

    // Reset held for two edges with a valid operation presented.
    drive(1'b1, 4'd5, 4'd3, 1'b1, 1'b1);
    check_all("reset0", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd5, 4'd3, 1'b1, 1'b1);
    check_all("reset1", 4'd0, 1'b0, 1'b0, 1'b0);
    // First result right after reset falls: 5+3+1 = 9, signed overflow.
    drive(1'b0, 4'd5, 4'd3, 1'b1, 1'b1);
    check_all("post_reset", 4'd9, 1'b0, 1'b1, 1'b1);

    // Counting sweep: a=b=0..8 then 0; ci=1 from the 9th step.
    for (int i = 0; i < 10; i++) begin
      logic [3:0] av;
      logic       cv;
      av   = 4'(i % 9);
      cv   = (i >= 8);
      full = 5'(av) + 5'(av) + 5'(cv);
      drive(1'b0, av, av, cv, 1'b1);
      check($sformatf("sweep%0d.s", i), 32'(bus.s), 32'(full[3:0]));
      check($sformatf("sweep%0d.cout", i), 32'(bus.cout), 32'(full[4]));
    end
    // Last two sweep points explicitly: 8+8+1 = 17, then 0+0+1 = 1.
    // (already covered above; reconfirm the wrap endpoint by hand)
    drive(1'b0, 4'd8, 4'd8, 1'b1, 1'b1);
    check_all("sweep_top", 4'd1, 1'b1, 1'b1, 1'b1);

    // Full ripple through every stage.
    drive(1'b0, 4'd15, 4'd0, 1'b1, 1'b1);
    check_all("ripple_15_0_1", 4'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'd15, 4'd15, 1'b1, 1'b1);
    check_all("max_15_15_1", 4'd15, 1'b1, 1'b0, 1'b1);

    // Signed overflow in both directions.
    drive(1'b0, 4'd7, 4'd1, 1'b0, 1'b1);
    check_all("ovf_7_1", 4'd8, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 4'd8, 4'd8, 1'b0, 1'b1);
    check_all("ovf_8_8", 4'd0, 1'b1, 1'b1, 1'b1);

    // Hold when in_valid is low, then resume.
    drive(1'b0, 4'd3, 4'd5, 1'b0, 1'b1);
    check_all("hold_load", 4'd8, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 4'd1, 4'd1, 1'b0, 1'b0);
    check_all("hold_idle", 4'd8, 1'b0, 1'b1, 1'b0);
    // Input changes between edges must not reach the outputs.
    bus.a = 4'd15;
    bus.b = 4'd15;
    #2;
    check_all("between_edges", 4'd8, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'd1, 4'd1, 1'b0, 1'b1);
    check_all("hold_resume", 4'd2, 1'b0, 1'b0, 1'b1);

    // Operation sampled with reset high is discarded and never surfaces.
    drive(1'b1, 4'd6, 4'd6, 1'b0, 1'b1);
    check_all("rst_mid_op", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd6, 4'd6, 1'b0, 1'b0);
    check_all("rst_mid_after", 4'd0, 1'b0, 1'b0, 1'b0);

    // Exhaustive: every a, b, ci.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          full = 5'(ai) + 5'(bi) + 5'(ci);
          sgn  = (ai >= 8 ? ai - 16 : ai) + (bi >= 8 ? bi - 16 : bi) + ci;
          eovf = (sgn > 7) || (sgn < -8);
          drive(1'b0, 4'(ai), 4'(bi), 1'(ci), 1'b1);
          check($sformatf("exh_%0d_%0d_%0d.sum", ai, bi, ci),
                32'({bus.cout, bus.s}), 32'(full));
          check($sformatf("exh_%0d_%0d_%0d.ovf", ai, bi, ci), 32'(bus.ovf), 32'(eovf));
          check($sformatf("exh_%0d_%0d_%0d.vld", ai, bi, ci), 32'(bus.out_valid), 32'd1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- Parameterised ripple-carry adder: a + b + ci produces a WIDTH-bit sum and a carry-out; default WIDTH is 4.
- The carry ripples combinationally through a chain of 1-bit full adders.
- Results are captured in an output register, giving one-cycle latency and a clean registered interface for downstream datapath logic.
- A valid strobe travels alongside the data.

Parameters:
- WIDTH, 4, operand and sum width in bits (must be >= 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- s  output  WIDTH  registered sum, (a+b+ci) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB stage.
- ovf  output  1  registered two's-complement overflow (carry into MSB XOR carry out of MSB).
- out_valid  output  1  high for the cycle in which s/cout/ovf hold a result for a sampled in_valid.
- a  input  WIDTH  operand A, unsigned (or two's complement when ovf is used).
- b  input  WIDTH  operand B.
- ci  input  1  carry-in to the LSB stage.
- in_valid  input  1  qualifies a/b/ci for capture this cycle.

Behaviour:
- Combinational core, stage i for i = 0..WIDTH-1:
  - sum_i = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c[0] = ci.
- The core is a true ripple chain of full-adder instances. No carry-lookahead, and no behavioural "+" for the full result.
- On each rising clk with rst = 1: s, cout, ovf and out_valid all clear to 0. rst overrides in_valid.
- On each rising clk with rst = 0 and in_valid = 1: s, cout and ovf load the core results for the current a/b/ci, and out_valid is set to 1.
- On each rising clk with rst = 0 and in_valid = 0: s, cout and ovf hold their previous values, and out_valid is set to 0.
- Latency: exactly 1 cycle from a sampled input to its result.
- Throughput: one new operation per cycle. Back-to-back in_valid produces back-to-back out_valid.
- Inputs are sampled only at the clock edge. Changes between edges have no effect on the outputs.
- Wrap-around: the sum is taken modulo 2^WIDTH and the lost bit appears on cout. Example: 15+1+0 gives s = 0, cout = 1.
- Maximum case: (2^WIDTH-1) + (2^WIDTH-1) + 1 gives s = 2^WIDTH-1, cout = 1.
- Reset mid-operation: an operation sampled in the same cycle as rst = 1 is discarded. No result for it ever appears.
- No internal state exists beyond the output registers.

Decomposition:
- No shared package is needed. WIDTH is the only constant and stays local to the block.
- One sub-module, full_adder: inputs a, b, cin; outputs sum, cout; purely combinational.
  - ripple_carry_adder instantiates WIDTH copies of it in a generate loop, chained cout-to-cin.
  - ovf is derived from c[WIDTH-1] XOR c[WIDTH].

Test Plan:
- Reset: hold rst = 1 for 2 cycles with a=5, b=3, ci=1, in_valid=1 -> s=0, cout=0, ovf=0, out_valid=0 throughout; first result appears 1 cycle after rst falls.
- Counting sweep: a and b step together 0..8 and wrap to 0, ci=0 for 8 cycles then ci=1, in_valid=1 -> each cycle s=(a+b+ci) mod 16 and cout correct (a=b=8, ci=1 -> s=1, cout=1), checked 1 cycle later.
- Full ripple: a=15, b=0, ci=1 -> s=0, cout=1, ovf=0. Then a=15, b=15, ci=1 -> s=15, cout=1.
- Signed overflow: a=7, b=1, ci=0 -> s=8, cout=0, ovf=1. Then a=8, b=8, ci=0 -> s=0, cout=1, ovf=1.
- Hold/valid: result 3+5=8 captured, then in_valid=0 with a=1, b=1 -> s stays 8, out_valid=0; reasserting in_valid gives s=2 the next cycle.
- Exhaustive: all 512 combinations of a, b, ci with in_valid=1 -> each registered {cout,s} equals a+b+ci, 1 cycle later.
